spi_periph_rx: RTL and testbench

SPI mode-0 peripheral-side deserializer: the receiving end of the display-controller SPI link, used as a loopback/bus-monitor model and as the read-back responder for ILI9341 register reads. It oversamples SCLK, CS_N, MOSI and DCX with the system clock and assembles MSB-first words. Each completed word is emitted with a one-cycle valid strobe. It simultaneously drives MISO from a host-loaded transmit holding register.

---
 rtl/spi_periph_rx.sv | 208 ++++++++++++++++++++
 tb/tb_spi_periph_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_periph_rx.sv
// SPI mode-0 peripheral deserializer: oversamples the SPI pins with clk, assembles
// MSB-first words with a one-cycle valid strobe, and returns a host-loaded word on MISO.
module spi_periph_rx #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_sclk,
  input  logic          i_cs_n,
  input  logic          i_mosi,
  input  logic          i_dcx,
  output logic          o_miso,
  output logic [DW-1:0] o_rx_data,
  output logic          o_rx_dc,
  output logic          o_rx_valid,
  output logic          o_frame_err,
  input  logic [DW-1:0] i_tx_data,
  input  logic          i_tx_we,
  output logic          o_dbg_active
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Handshake: o_rx_valid is a one-cycle strobe with no ready; o_rx_data/o_rx_dc
  // are stable from the strobe until the next strobe. i_tx_we is accepted every cycle.

  // Pin synchronizers
  logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic       r_cs_s1, r_cs_s2, r_cs_d;
  logic       r_mosi_s1, r_mosi_s2;
  logic       r_dcx_s1, r_dcx_s2;
  logic [1:0] r_fill;
  logic       r_armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_mosi_s1 <= 1'b1;
      r_mosi_s2 <= 1'b1;
      r_dcx_s1  <= 1'b0;
      r_dcx_s2  <= 1'b0;
      r_fill    <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= i_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_dcx_s1  <= i_dcx;
      r_dcx_s2  <= r_dcx_s1;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
      // Reset values in the chain are not real observations; wait until it has
      // refilled with pin samples before trusting a high cs_n.
      if (r_fill == 2'd3 && r_cs_s2) begin
        r_armed <= 1'b1;
      end
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_d & r_armed;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

  // Frame state machine
  state_t          r_state;
  state_t          w_next;
  logic            w_start, w_end, w_rx_bit, w_tx_edge, w_load;
  logic [CW-1:0]   r_bitcnt;
  logic            r_seen_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_end     = 1'b0;
    w_rx_bit  = 1'b0;
    w_tx_edge = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_next  = ACTIVE;
          w_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          // cs_n wins over a coincident sclk edge: that bit is dropped.
          w_next = IDLE;
          w_end  = 1'b1;
        end else begin
          w_rx_bit  = w_sclk_rise;
          w_tx_edge = w_sclk_fall & r_seen_rise;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_load = w_start | (w_tx_edge & (r_bitcnt == '0));

  // Datapath
  logic [DW-2:0] r_shift_in;
  logic [DW-1:0] r_shift_out;
  logic [DW-1:0] r_hold;
  logic          r_pend;
  logic [DW-1:0] r_rx_data;
  logic          r_rx_dc;
  logic          r_rx_valid;
  logic          r_frame_err;
  logic [DW-1:0] w_word_in;
  logic [DW-1:0] w_load_word;

  assign w_word_in   = {r_shift_in, r_mosi_s2};
  assign w_load_word = i_tx_we ? i_tx_data : (r_pend ? r_hold : {DW{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
      r_pend <= 1'b0;
    end else if (w_load) begin
      r_pend <= 1'b0;
    end else if (i_tx_we) begin
      r_hold <= i_tx_data;
      r_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitcnt    <= '0;
      r_seen_rise <= 1'b0;
      r_shift_in  <= '1;
      r_shift_out <= '1;
      r_rx_data   <= '0;
      r_rx_dc     <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_bitcnt    <= '0;
        r_seen_rise <= 1'b0;
        r_shift_out <= w_load_word;
      end else if (w_end) begin
        r_frame_err <= (r_bitcnt != '0);
        r_bitcnt    <= '0;
        r_shift_in  <= '1;
      end else begin
        if (w_rx_bit) begin
          r_shift_in  <= w_word_in[DW-2:0];
          r_seen_rise <= 1'b1;
          if (r_bitcnt == LAST_BIT) begin
            r_rx_data  <= w_word_in;
            r_rx_dc    <= r_dcx_s2;
            r_rx_valid <= 1'b1;
            r_bitcnt   <= '0;
          end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
          end
        end
        // A falling edge right after a word boundary presents the next word's MSB.
        if (w_tx_edge) begin
          if (r_bitcnt == '0) begin
            r_shift_out <= w_load_word;
          end else begin
            r_shift_out <= {r_shift_out[DW-2:0], 1'b1};
          end
        end
      end
    end
  end

  assign o_miso       = (r_state == ACTIVE) ? r_shift_out[DW-1] : 1'b1;
  assign o_rx_data    = r_rx_data;
  assign o_rx_dc      = r_rx_dc;
  assign o_rx_valid   = r_rx_valid;
  assign o_frame_err  = r_frame_err;
  assign o_dbg_active = (r_state == ACTIVE);

endmodule

// File: tb/tb_spi_periph_rx.sv
// Directed bench for spi_periph_rx: drives SPI mode-0 frames between clk edges
// and checks received words, MISO read-back, frame errors and reset behaviour.
module tb_spi_periph_rx;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk, cs_n, mosi, dcx, tx_we;
  logic [DW-1:0] tx_data;
  logic          miso, rx_dc, rx_valid, frame_err, dbg_active;
  logic [DW-1:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_ferr   = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] got_q[$];

  spi_periph_rx #(.DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_sclk       (sclk),
    .i_cs_n       (cs_n),
    .i_mosi       (mosi),
    .i_dcx        (dcx),
    .o_miso       (miso),
    .o_rx_data    (rx_data),
    .o_rx_dc      (rx_dc),
    .o_rx_valid   (rx_valid),
    .o_frame_err  (frame_err),
    .i_tx_data    (tx_data),
    .i_tx_we      (tx_we),
    .o_dbg_active (dbg_active)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // received-word monitor
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back({rx_dc, rx_data});
    if (frame_err) n_ferr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    logic [DW:0] e;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) chk(tag, 32'(got_q.pop_front()), 32'(e));
    end
    got_q.delete();
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    idle(6);
  endtask

  task automatic cs_high();
    idle(2);
    cs_n = 1'b1;
    idle(8);
  endtask

  task automatic pulse_we(input logic [DW-1:0] v);
    tx_data = v;
    tx_we   = 1'b1;
    @(negedge clk);
    tx_we   = 1'b0;
  endtask

  task automatic xfer(input logic [DW-1:0] w, input logic dc, input int half, input int nbits,
                      input logic we_on_valid, input logic [DW-1:0] we_val,
                      output logic [DW-1:0] mw);
    mw = '1;
    for (int i = DW - 1; i >= DW - nbits; i--) begin
      mosi = w[i];
      dcx  = dc;
      idle(half);
      sclk = 1'b1;
      if (i == 0 && we_on_valid) begin
        int k;
        k = 0;
        while (!rx_valid && k < 16) begin
          @(negedge clk);
          k++;
        end
        chk("valid_before_we", 32'(rx_valid), 32'd1);
        pulse_we(we_val);
      end else begin
        idle(half);
      end
      mw[i] = miso;
      sclk = 1'b0;
    end
  endtask

  logic [DW-1:0] mw1, mw2;
  int ferr0;

  initial begin
    rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b1; dcx = 1'b0;
    tx_we = 1'b0; tx_data = '0;
    idle(3);
    chk("rst_miso", 32'(miso), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_dc", 32'(rx_dc), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_state", 32'(dbg_active), 32'd0);
    rst = 1'b1;
    idle(5);

    // single word, empty TX
    ferr0 = n_ferr;
    cs_low();
    chk("active_after_cs", 32'(dbg_active), 32'd1);
    xfer(8'hA5, 1'b1, 4, 8, 1'b0, 8'h00, mw1);
    cs_high();
    exp_q.push_back({1'b1, 8'hA5});
    check_rx("single");
    chk("single_rx_data", 32'(rx_data), 32'hA5);
    chk("single_rx_dc", 32'(rx_dc), 32'd1);
    chk("single_no_ferr", 32'(n_ferr - ferr0), 32'd0);
    chk("empty_tx_miso", 32'(mw1), 32'hFF);
    chk("idle_miso", 32'(miso), 32'd1);
    chk("idle_state", 32'(dbg_active), 32'd0);

    // burst with read-back
    pulse_we(8'h3C);
    idle(2);
    cs_low();
    xfer(8'h11, 1'b0, 4, 8, 1'b1, 8'hC3, mw1);
    xfer(8'h22, 1'b1, 4, 8, 1'b0, 8'h00, mw2);
    cs_high();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    check_rx("burst");
    chk("burst_miso0", 32'(mw1), 32'h3C);
    chk("burst_miso1", 32'(mw2), 32'hC3);

    // abort after 5 bits, then a clean frame
    ferr0 = n_ferr;
    cs_low();
    xfer(8'hE7, 1'b0, 4, 5, 1'b0, 8'h00, mw1);
    cs_high();
    check_rx("abort");
    chk("abort_ferr", 32'(n_ferr - ferr0), 32'd1);
    chk("abort_rx_data_kept", 32'(rx_data), 32'h22);
    chk("abort_rx_dc_kept", 32'(rx_dc), 32'd1);
    cs_low();
    xfer(8'h5A, 1'b0, 4, 8, 1'b0, 8'h00, mw1);
    cs_high();
    exp_q.push_back({1'b0, 8'h5A});
    check_rx("after_abort");

    // reset mid-frame with cs_n held low
    ferr0 = n_ferr;
    cs_low();
    xfer(8'hF0, 1'b1, 4, 3, 1'b0, 8'h00, mw1);
    rst = 1'b0;
    idle(2);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    chk("midrst_miso", 32'(miso), 32'd1);
    chk("midrst_state", 32'(dbg_active), 32'd0);
    rst = 1'b1;
    idle(6);
    xfer(8'hFF, 1'b1, 4, 8, 1'b0, 8'h00, mw1);
    idle(6);
    check_rx("unarmed");
    chk("unarmed_state", 32'(dbg_active), 32'd0);
    chk("unarmed_miso", 32'(mw1), 32'hFF);
    chk("unarmed_ferr", 32'(n_ferr - ferr0), 32'd0);
    cs_high();
    cs_low();
    xfer(8'h81, 1'b1, 4, 8, 1'b0, 8'h00, mw1);
    cs_high();
    exp_q.push_back({1'b1, 8'h81});
    check_rx("rearmed");

    // minimum SCLK phases, back-to-back words
    ferr0 = n_ferr;
    pulse_we(8'h96);
    idle(2);
    cs_low();
    xfer(8'hFF, 1'b0, 2, 8, 1'b1, 8'h69, mw1);
    xfer(8'h00, 1'b1, 2, 8, 1'b0, 8'h00, mw2);
    cs_high();
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b1, 8'h00});
    check_rx("fast");
    chk("fast_miso0", 32'(mw1), 32'h96);
    chk("fast_miso1", 32'(mw2), 32'h69);
    chk("fast_no_ferr", 32'(n_ferr - ferr0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
